mem_boot_loader: RTL and testbench

//  Sequences the power-on load of the program image into the Memory block before the FSA runs.

---
 rtl/mem_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_mem_boot_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_boot_loader.sv
// Power-on image loader: writes IMAGE_BYTES bytes into Memory from START_ADDR, one
// req/ack handshake per byte, holding the CPU off until the image is in place.
module mem_boot_loader #(
    parameter int                IMAGE_BYTES = 15,
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] START_ADDR  = '0,
    parameter int                WAIT_MAX    = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  loadMem,
    input  logic [IMAGE_BYTES-1:0][DATA_W-1:0]    initial_memory,
    output logic                                  mem_req,
    output logic [ADDR_W-1:0]                     mem_addr,
    output logic [DATA_W-1:0]                     mem_wdata,
    input  logic                                  mem_ack,
    output logic                                  hold_cpu,
    output logic                                  loadMemComplete,
    output logic                                  load_error,
    output logic [$clog2(IMAGE_BYTES+1)-1:0]      byte_idx
);

    localparam int IDX_W  = $clog2(IMAGE_BYTES + 1);
    localparam int SEL_W  = (IMAGE_BYTES > 1) ? $clog2(IMAGE_BYTES) : 1;
    localparam int WCNT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state_reg, state_next;

    logic              mem_req_reg,   mem_req_next;
    logic [ADDR_W-1:0] mem_addr_reg,  mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
    logic              hold_cpu_reg,  hold_cpu_next;
    logic              complete_reg,  complete_next;
    logic              error_reg,     error_next;
    logic [IDX_W-1:0]  byte_idx_reg,  byte_idx_next;
    logic [WCNT_W-1:0] wait_cnt_reg,  wait_cnt_next;

    logic [DATA_W-1:0] image_bytes [IMAGE_BYTES];
    logic [IDX_W-1:0]  idx_inc;
    logic              last_byte;
    logic              wait_expired;
    logic              start;

    generate
        for (genvar gi = 0; gi < IMAGE_BYTES; gi++) begin : g_unpack
            assign image_bytes[gi] = initial_memory[gi];
        end
    endgenerate

    assign idx_inc      = byte_idx_reg + IDX_W'(1);
    assign last_byte    = (idx_inc == IDX_W'(IMAGE_BYTES));
    assign wait_expired = (wait_cnt_reg == WCNT_W'(WAIT_MAX - 1));
    // A load in flight (ISSUE/WAIT_ACK) is never restarted by loadMem.
    assign start        = loadMem && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                                      (state_reg == S_ERROR));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) state_next = S_ISSUE;
            end
            S_ISSUE: state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (mem_ack) begin
                    state_next = last_byte ? S_DONE : S_ISSUE;
                end else if (wait_expired) begin
                    state_next = S_ERROR;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_next   = mem_req_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        hold_cpu_next  = hold_cpu_reg;
        complete_next  = complete_reg;
        error_next     = error_reg;
        byte_idx_next  = byte_idx_reg;
        wait_cnt_next  = wait_cnt_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERROR: begin
                mem_req_next = 1'b0;
                if (start) begin
                    byte_idx_next = '0;
                    wait_cnt_next = '0;
                    complete_next = 1'b0;
                    error_next    = 1'b0;
                    hold_cpu_next = 1'b1;
                end
            end
            S_ISSUE: begin
                // Address wraps modulo 2^ADDR_W by construction of the sum width.
                mem_addr_next  = START_ADDR + ADDR_W'(byte_idx_reg);
                mem_wdata_next = image_bytes[byte_idx_reg[SEL_W-1:0]];
                mem_req_next   = 1'b1;
                wait_cnt_next  = '0;
            end
            S_WAIT_ACK: begin
                if (mem_ack) begin
                    mem_req_next  = 1'b0;
                    byte_idx_next = idx_inc;
                    if (last_byte) begin
                        complete_next = 1'b1;
                        hold_cpu_next = 1'b0;
                    end
                end else if (wait_expired) begin
                    mem_req_next = 1'b0;
                    error_next   = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
                end
            end
            default: mem_req_next = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_reg   <= 1'b0;
            mem_addr_reg  <= START_ADDR;
            mem_wdata_reg <= '0;
            hold_cpu_reg  <= 1'b1;
            complete_reg  <= 1'b0;
            error_reg     <= 1'b0;
            byte_idx_reg  <= '0;
            wait_cnt_reg  <= '0;
        end else begin
            mem_req_reg   <= mem_req_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            hold_cpu_reg  <= hold_cpu_next;
            complete_reg  <= complete_next;
            error_reg     <= error_next;
            byte_idx_reg  <= byte_idx_next;
            wait_cnt_reg  <= wait_cnt_next;
        end
    end

    assign mem_req         = mem_req_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign hold_cpu        = hold_cpu_reg;
    assign loadMemComplete = complete_reg;
    assign load_error      = error_reg;
    assign byte_idx        = byte_idx_reg;

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: nominal, delayed-ack, stall/retry, async reset,
// held loadMem and address wrap scenarios, with hand-computed expectations.
module tb_mem_boot_loader;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic                 loadMem = 1'b0;
    logic                 loadMem2 = 1'b0;
    logic [14:0][7:0]     initial_memory;
    logic                 mem_req, mem_ack, hold_cpu, loadMemComplete, load_error;
    logic [15:0]          mem_addr;
    logic [7:0]           mem_wdata;
    logic [3:0]           byte_idx;
    logic                 mem_req2, mem_ack2, hold_cpu2, complete2, error2;
    logic [15:0]          mem_addr2;
    logic [7:0]           mem_wdata2;
    logic [3:0]           byte_idx2;

    int n_checks = 0;
    int n_fail   = 0;

    int ack_delay  = 0;
    int stall_byte = -1;
    int req_cnt    = 0;

    logic [15:0] wr_addr [64];
    logic [7:0]  wr_data [64];
    int          wr_n = 0;
    logic [15:0] wr2_addr [64];
    logic [7:0]  wr2_data [64];
    int          wr2_n = 0;
    int          unstable = 0;
    logic        prev_req = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;

    always #5 clock = ~clock;

    mem_boot_loader #(
        .IMAGE_BYTES(15), .ADDR_W(16), .DATA_W(8), .START_ADDR(16'h0000), .WAIT_MAX(8)
    ) dut (
        .clock(clock), .reset(reset), .loadMem(loadMem), .initial_memory(initial_memory),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .hold_cpu(hold_cpu), .loadMemComplete(loadMemComplete), .load_error(load_error),
        .byte_idx(byte_idx)
    );

    mem_boot_loader #(
        .IMAGE_BYTES(15), .ADDR_W(16), .DATA_W(8), .START_ADDR(16'hFFFA), .WAIT_MAX(8)
    ) u_wrap (
        .clock(clock), .reset(reset), .loadMem(loadMem2), .initial_memory(initial_memory),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_ack(mem_ack2),
        .hold_cpu(hold_cpu2), .loadMemComplete(complete2), .load_error(error2),
        .byte_idx(byte_idx2)
    );

    // Memory responder: ack after ack_delay request cycles, never for the stalled byte.
    assign mem_ack  = mem_req && (req_cnt >= ack_delay) &&
                      ((stall_byte < 0) || (int'(byte_idx) != stall_byte));
    assign mem_ack2 = mem_req2;

    always @(posedge clock) begin
        if (!mem_req || mem_ack) req_cnt <= 0;
        else                     req_cnt <= req_cnt + 1;
    end

    always @(posedge clock) begin
        if (reset && mem_req && mem_ack && wr_n < 64) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            $display("write addr=%h data=%h", mem_addr, mem_wdata);
            wr_n++;
        end
        if (reset && mem_req && prev_req && (mem_addr !== prev_addr || mem_wdata !== prev_data))
            unstable++;
        prev_req  = mem_req && !mem_ack;
        prev_addr = mem_addr;
        prev_data = mem_wdata;
        if (reset && mem_req2 && mem_ack2 && wr2_n < 64) begin
            wr2_addr[wr2_n] = mem_addr2;
            wr2_data[wr2_n] = mem_wdata2;
            $display("wrap write addr=%h data=%h", mem_addr2, mem_wdata2);
            wr2_n++;
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0; loadMem = 1'b0; loadMem2 = 1'b0;
        ack_delay = 0; stall_byte = -1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        wr_n = 0; wr2_n = 0; unstable = 0;
    endtask

    task automatic launch();
        @(negedge clock);
        loadMem = 1'b1;
        @(negedge clock);
        loadMem = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", mem_req); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got=%h exp=0000", mem_addr); end
        n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", mem_wdata); end
        n_checks++; if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL reset_hold got=%b exp=1", hold_cpu); end
        n_checks++; if ({loadMemComplete, load_error} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {loadMemComplete, load_error}); end
        n_checks++; if (byte_idx !== 4'd0) begin n_fail++; $display("FAIL reset_idx got=%0d exp=0", byte_idx); end
        n_checks++; if (mem_addr2 !== 16'hFFFA) begin n_fail++; $display("FAIL reset_addr_wrap got=%h exp=fffa", mem_addr2); end
        $display("test_reset done");
    endtask

    task automatic test_basic_load();
        do_reset();
        launch();
        repeat (29) @(negedge clock);
        n_checks++; if (loadMemComplete !== 1'b0) begin n_fail++; $display("FAIL basic_early_done got=%b exp=0", loadMemComplete); end
        n_checks++; if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL basic_early_hold got=%b exp=1", hold_cpu); end
        @(negedge clock);
        n_checks++; if (loadMemComplete !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", loadMemComplete); end
        n_checks++; if (hold_cpu !== 1'b0) begin n_fail++; $display("FAIL basic_hold got=%b exp=0", hold_cpu); end
        n_checks++; if (byte_idx !== 4'd15) begin n_fail++; $display("FAIL basic_idx got=%0d exp=15", byte_idx); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL basic_req got=%b exp=0", mem_req); end
        n_checks++; if (wr_n !== 15) begin n_fail++; $display("FAIL basic_count got=%0d exp=15", wr_n); end
        for (int i = 0; i < 15 && i < wr_n; i++) begin
            n_checks++;
            if (wr_addr[i] !== 16'(i) || wr_data[i] !== 8'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL basic_write%0d got=%h/%h exp=%h/%h", i, wr_addr[i], wr_data[i], 16'(i), 8'(8'h10 + i));
            end
        end
        $display("test_basic_load done");
    endtask

    task automatic test_delayed_ack();
        do_reset();
        ack_delay = 3;
        launch();
        repeat (74) @(negedge clock);
        n_checks++; if (loadMemComplete !== 1'b0) begin n_fail++; $display("FAIL delay_early_done got=%b exp=0", loadMemComplete); end
        @(negedge clock);
        n_checks++; if (loadMemComplete !== 1'b1) begin n_fail++; $display("FAIL delay_done got=%b exp=1", loadMemComplete); end
        n_checks++; if (load_error !== 1'b0) begin n_fail++; $display("FAIL delay_error got=%b exp=0", load_error); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL delay_stable got=%0d exp=0", unstable); end
        n_checks++; if (wr_n !== 15) begin n_fail++; $display("FAIL delay_count got=%0d exp=15", wr_n); end
        n_checks++; if (wr_addr[14] !== 16'd14 || wr_data[14] !== 8'h1E) begin n_fail++; $display("FAIL delay_last got=%h/%h exp=000e/1e", wr_addr[14], wr_data[14]); end
        $display("test_delayed_ack done");
    endtask

    task automatic test_stall_retry();
        do_reset();
        stall_byte = 5;
        launch();
        repeat (18) @(negedge clock);
        n_checks++; if ({load_error, mem_req} !== 2'b01) begin n_fail++; $display("FAIL stall_waiting got=%b exp=01", {load_error, mem_req}); end
        @(negedge clock);
        n_checks++; if (load_error !== 1'b1) begin n_fail++; $display("FAIL stall_error got=%b exp=1", load_error); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req got=%b exp=0", mem_req); end
        n_checks++; if (byte_idx !== 4'd5) begin n_fail++; $display("FAIL stall_idx got=%0d exp=5", byte_idx); end
        n_checks++; if (hold_cpu !== 1'b1) begin n_fail++; $display("FAIL stall_hold got=%b exp=1", hold_cpu); end
        stall_byte = -1;
        launch();
        n_checks++; if ({load_error, byte_idx} !== 5'b0_0000) begin n_fail++; $display("FAIL retry_clear got=%b exp=00000", {load_error, byte_idx}); end
        repeat (30) @(negedge clock);
        n_checks++; if ({loadMemComplete, load_error} !== 2'b10) begin n_fail++; $display("FAIL retry_done got=%b exp=10", {loadMemComplete, load_error}); end
        n_checks++; if (wr_n !== 20) begin n_fail++; $display("FAIL retry_count got=%0d exp=20", wr_n); end
        n_checks++; if (wr_addr[5] !== 16'd0 || wr_addr[19] !== 16'd14) begin n_fail++; $display("FAIL retry_addrs got=%h,%h exp=0000,000e", wr_addr[5], wr_addr[19]); end
        $display("test_stall_retry done");
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        launch();
        repeat (15) @(negedge clock);
        n_checks++; if ({mem_req, mem_addr} !== {1'b1, 16'd7}) begin n_fail++; $display("FAIL mid_pre got=%b/%h exp=1/0007", mem_req, mem_addr); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req got=%b exp=0", mem_req); end
        n_checks++; if ({mem_addr, mem_wdata} !== 24'h0000_00) begin n_fail++; $display("FAIL mid_bus got=%h/%h exp=0000/00", mem_addr, mem_wdata); end
        n_checks++; if ({hold_cpu, loadMemComplete, load_error, byte_idx} !== 7'b100_0000) begin n_fail++; $display("FAIL mid_status got=%b exp=1000000", {hold_cpu, loadMemComplete, load_error, byte_idx}); end
        @(negedge clock);
        reset = 1'b1;
        wr_n = 0;
        launch();
        repeat (30) @(negedge clock);
        n_checks++; if (loadMemComplete !== 1'b1) begin n_fail++; $display("FAIL mid_reload_done got=%b exp=1", loadMemComplete); end
        n_checks++; if (wr_n !== 15 || wr_addr[0] !== 16'd0) begin n_fail++; $display("FAIL mid_restart got=%0d/%h exp=15/0000", wr_n, wr_addr[0]); end
        $display("test_reset_mid_load done");
    endtask

    task automatic test_back_to_back();
        int   rises = 0;
        int   falls = 0;
        int   r1 = 0;
        int   r2 = 0;
        logic prev_c;
        do_reset();
        @(negedge clock);
        loadMem = 1'b1;
        prev_c = loadMemComplete;
        for (int c = 1; c <= 200 && rises < 2; c++) begin
            @(negedge clock);
            if (loadMemComplete && !prev_c) begin
                rises++;
                if (rises == 1) r1 = c; else r2 = c;
            end
            if (!loadMemComplete && prev_c) falls++;
            prev_c = loadMemComplete;
        end
        loadMem = 1'b0;
        repeat (5) @(negedge clock);
        n_checks++; if (r1 !== 31) begin n_fail++; $display("FAIL b2b_first_rise got=%0d exp=31", r1); end
        n_checks++; if (r2 !== 62) begin n_fail++; $display("FAIL b2b_second_rise got=%0d exp=62", r2); end
        n_checks++; if (falls !== 1) begin n_fail++; $display("FAIL b2b_falls got=%0d exp=1", falls); end
        n_checks++; if (loadMemComplete !== 1'b1) begin n_fail++; $display("FAIL b2b_final got=%b exp=1", loadMemComplete); end
        n_checks++; if (wr_n !== 30) begin n_fail++; $display("FAIL b2b_count got=%0d exp=30", wr_n); end
        for (int i = 0; i < 30 && i < wr_n; i++) begin
            n_checks++;
            if (wr_addr[i] !== 16'(i % 15)) begin
                n_fail++;
                $display("FAIL b2b_addr%0d got=%h exp=%h", i, wr_addr[i], 16'(i % 15));
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_wrap();
        logic [15:0] exp_addr;
        do_reset();
        @(negedge clock);
        loadMem2 = 1'b1;
        @(negedge clock);
        loadMem2 = 1'b0;
        repeat (30) @(negedge clock);
        n_checks++; if (complete2 !== 1'b1) begin n_fail++; $display("FAIL wrap_done got=%b exp=1", complete2); end
        n_checks++; if (wr2_n !== 15) begin n_fail++; $display("FAIL wrap_count got=%0d exp=15", wr2_n); end
        for (int i = 0; i < 15 && i < wr2_n; i++) begin
            exp_addr = 16'hFFFA + 16'(i);
            n_checks++;
            if (wr2_addr[i] !== exp_addr || wr2_data[i] !== 8'(8'h10 + i)) begin
                n_fail++;
                $display("FAIL wrap_write%0d got=%h/%h exp=%h/%h", i, wr2_addr[i], wr2_data[i], exp_addr, 8'(8'h10 + i));
            end
        end
        $display("test_wrap done");
    endtask

    initial begin
        for (int i = 0; i < 15; i++) initial_memory[i] = 8'(8'h10 + i);
        test_reset();
        test_basic_load();
        test_delayed_ack();
        test_stall_retry();
        test_reset_mid_load();
        test_back_to_back();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
